// File: rtl/code_sequencer_if.sv
// Board-key / decoder-code bundle for code_sequencer.
//
// Handshake: code_upd qualifies code. code_upd is high for exactly one
// cycle, in the first cycle that code shows a new value. No pulse means no
// change. There is no ready/backpressure: the decoder is combinational and
// always accepts. mode is a live view of the sequencer state.
interface code_sequencer_if;
    logic       key_step;   // raw step button, active-low
    logic       key_mode;   // raw mode button, active-low
    logic [2:0] code;       // code[2]->in1, code[1]->in2, code[0]->in3
    logic       code_upd;   // one-cycle pulse on every code change
    logic [1:0] mode;       // current sequencer state

    // Drives the buttons and observes the code (board / testbench side).
    modport master (
        output key_step,
        output key_mode,
        input  code,
        input  code_upd,
        input  mode
    );

    // Sequencer side.
    modport slave (
        input  key_step,
        input  key_mode,
        output code,
        output code_upd,
        output mode
    );
endinterface

// File: rtl/code_sequencer.sv
// code_sequencer: debounces two push-buttons and produces the 3-bit code
// for the 3-to-8 one-hot decoder. Modes: manual step, auto count up,
// auto count down, and hold. The state is exported on bus.mode.
module code_sequencer #(
    parameter int DEB_MAX = 999_999,     // press accepted after DEB_MAX+1 stable-low cycles
    parameter int CNT_MAX = 24_999_999   // auto tick every CNT_MAX+1 cycles
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    code_sequencer_if.slave    bus
);

    localparam int DW = (DEB_MAX > 0) ? $clog2(DEB_MAX + 1) : 1;
    localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [DW-1:0] DEB_TOP = DW'(DEB_MAX);
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

    typedef enum logic [1:0] {
        MANUAL    = 2'd0,
        AUTO_UP   = 2'd1,
        AUTO_DOWN = 2'd2,
        HOLD      = 2'd3
    } state_t;

    // Key index 0 is step and index 1 is mode.
    logic [1:0]         key_raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0][DW-1:0] deb_cnt;
    logic [1:0]         deb_sat;   // counter was already at DEB_TOP last cycle
    logic [1:0]         press;     // one-cycle accepted-press pulse

    state_t             state;
    logic [2:0]         code;
    logic               code_upd;
    logic [CW-1:0]      div;

    logic               step_p;
    logic               mode_p;
    logic               tick;

    assign key_raw = {bus.key_mode, bus.key_step};
    assign step_p  = press[0];
    assign mode_p  = press[1];
    // The divider only runs in the auto states, so the tick is gated here too.
    assign tick    = ((state == AUTO_UP) || (state == AUTO_DOWN)) && (div == CNT_TOP);

    assign bus.code     = code;
    assign bus.code_upd = code_upd;
    assign bus.mode     = state;

    // Synchronise and debounce both keys.
    // Each key gives one registered pulse, one cycle after its counter first saturates.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            deb_cnt <= '0;
            deb_sat <= 2'b00;
            press   <= 2'b00;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != DEB_TOP) begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
                deb_sat[i] <= (deb_cnt[i] == DEB_TOP);
                press[i]   <= (deb_cnt[i] == DEB_TOP) && !deb_sat[i];
            end
        end
    end

    // Mode FSM, code register and auto-step divider.
    // A mode press pre-empts any step press or tick in the same cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= MANUAL;
            code     <= 3'd0;
            code_upd <= 1'b0;
            div      <= '0;
        end else begin
            code_upd <= 1'b0;
            if (mode_p) begin
                div <= '0;
                case (state)
                    MANUAL:    state <= AUTO_UP;
                    AUTO_UP:   state <= AUTO_DOWN;
                    AUTO_DOWN: state <= HOLD;
                    HOLD:      state <= MANUAL;
                    default:   state <= MANUAL;
                endcase
            end else begin
                case (state)
                    MANUAL: begin
                        div <= '0;
                        if (step_p) begin
                            code     <= code + 3'd1;
                            code_upd <= 1'b1;
                        end
                    end
                    AUTO_UP, AUTO_DOWN: begin
                        if (step_p) begin
                            // Restart from zero; a restart at zero is not a change.
                            div <= '0;
                            if (code != 3'd0) begin
                                code     <= 3'd0;
                                code_upd <= 1'b1;
                            end
                        end else if (tick) begin
                            div      <= '0;
                            code     <= (state == AUTO_UP) ? code + 3'd1 : code - 3'd1;
                            code_upd <= 1'b1;
                        end else begin
                            div <= div + CW'(1);
                        end
                    end
                    HOLD: begin
                        div <= '0;
                    end
                    default: begin
                        div <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
// Bench for code_sequencer with DEB_MAX=3 and CNT_MAX=4.
// A key driven low at the negedge after posedge n produces its action at posedge n+7.
// Auto ticks land every 5 cycles after the state is entered.
module tb_code_sequencer;

    logic clk = 1'b0;
    logic rst;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   upd_total   = 0;
    logic sb_en       = 1'b0;

    logic [2:0] exp_q[$];
    int         upd_t_q[$];
    logic [2:0] prev_code = 3'd0;
    logic [2:0] m_code    = 3'd0;
    int         b;

    code_sequencer_if bus ();

    code_sequencer #(
        .DEB_MAX(3),
        .CNT_MAX(4)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin : monitor
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && sb_en) begin
                if (bus.code_upd === 1'b1) begin
                    upd_total++;
                    upd_t_q.push_back(cyc);
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_upd: code=%0d at cycle %0d, no update expected", bus.code, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.code !== e) begin
                            miscompares++;
                            $display("FAIL code_value: got %0d expected %0d at cycle %0d", bus.code, e, cyc);
                        end
                    end
                    if (bus.code === prev_code) begin
                        miscompares++;
                        $display("FAIL upd_without_change: code stayed %0d at cycle %0d", bus.code, cyc);
                    end
                end else if (bus.code !== prev_code) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL silent_change: code %0d -> %0d with code_upd=0 at cycle %0d", prev_code, bus.code, cyc);
                end
            end
            prev_code = bus.code;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic at_neg(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press_step(input int hold);
        bus.key_step = 1'b0;
        repeat (hold) @(negedge clk);
        bus.key_step = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic step_manual();
        m_code = m_code + 3'd1;
        exp_q.push_back(m_code);
        press_step(10);
    endtask

    task automatic check_time(input string name, input int exp_t);
        int t;
        vectors++;
        if (upd_t_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got no update expected update at cycle %0d", name, exp_t);
        end else begin
            t = upd_t_q.pop_front();
            if (t !== exp_t) begin
                miscompares++;
                $display("FAIL %s: got update at cycle %0d expected cycle %0d", name, t, exp_t);
            end
        end
    endtask

    task automatic check_empty(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected updates never arrived, expected 0 pending", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        rst          = 1'b1;
        bus.key_step = 1'b1;
        bus.key_mode = 1'b1;
        #2;
        vectors++;
        if (bus.code !== 3'd0) begin miscompares++; $display("FAIL reset_code: got %0d expected 0", bus.code); end
        vectors++;
        if (bus.mode !== 2'd0) begin miscompares++; $display("FAIL reset_mode: got %0d expected 0", bus.mode); end
        vectors++;
        if (bus.code_upd !== 1'b0) begin miscompares++; $display("FAIL reset_upd: got %b expected 0", bus.code_upd); end

        @(negedge clk);
        rst = 1'b0;
        bus.key_mode = 1'b0;
        repeat (10) @(negedge clk);
        bus.key_mode = 1'b1;
        n = 0;
        while (bus.code === 3'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.code === 3'd0) begin miscompares++; $display("FAIL auto_start: got code 0 expected nonzero within 40 cycles"); end
        vectors++;
        if (bus.mode !== 2'd1) begin miscompares++; $display("FAIL auto_mode: got %0d expected 1", bus.mode); end

        // Asynchronous reset away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.code !== 3'd0) begin miscompares++; $display("FAIL async_rst_code: got %0d expected 0", bus.code); end
        vectors++;
        if (bus.mode !== 2'd0) begin miscompares++; $display("FAIL async_rst_mode: got %0d expected 0", bus.mode); end
        vectors++;
        if (bus.code_upd !== 1'b0) begin miscompares++; $display("FAIL async_rst_upd: got %b expected 0", bus.code_upd); end
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_code = 3'd0;
        exp_q.delete();
        upd_t_q.delete();
        sb_en  = 1'b1;
    endtask

    task automatic test_manual_steps();
        int u0;
        u0 = upd_total;
        for (int i = 0; i < 9; i++) step_manual();
        vectors++;
        if (upd_total - u0 !== 9) begin miscompares++; $display("FAIL manual_pulses: got %0d expected 9", upd_total - u0); end
        vectors++;
        if (bus.code !== 3'd1) begin miscompares++; $display("FAIL manual_final: got %0d expected 1", bus.code); end
        check_empty("manual_pending");
        upd_t_q.delete();
    endtask

    task automatic test_glitch_and_hold();
        int u0;
        u0 = upd_total;
        bus.key_step = 1'b0;
        repeat (2) @(negedge clk);
        bus.key_step = 1'b1;
        repeat (15) @(negedge clk);
        vectors++;
        if (upd_total !== u0) begin miscompares++; $display("FAIL glitch_pulses: got %0d expected 0", upd_total - u0); end
        vectors++;
        if (bus.code !== m_code) begin miscompares++; $display("FAIL glitch_code: got %0d expected %0d", bus.code, m_code); end

        upd_t_q.delete();
        m_code = m_code + 3'd1;
        exp_q.push_back(m_code);
        u0 = upd_total;
        b  = cyc;
        bus.key_step = 1'b0;
        repeat (100) @(negedge clk);
        bus.key_step = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if (upd_total - u0 !== 1) begin miscompares++; $display("FAIL long_hold_pulses: got %0d expected 1", upd_total - u0); end
        vectors++;
        if (bus.code !== m_code) begin miscompares++; $display("FAIL long_hold_code: got %0d expected %0d", bus.code, m_code); end
        check_time("press_latency", b + 7);
        check_empty("hold_pending");
    endtask

    task automatic test_auto_up();
        for (int i = 0; i < 4; i++) step_manual();
        vectors++;
        if (bus.code !== 3'd6) begin miscompares++; $display("FAIL pre_auto_code: got %0d expected 6", bus.code); end
        upd_t_q.delete();

        b = cyc;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd0);
        bus.key_mode = 1'b0;                 // lands at b+7
        at_neg(b + 8);
        vectors++;
        if (bus.mode !== 2'd1) begin miscompares++; $display("FAIL up_mode: got %0d expected 1", bus.mode); end
        at_neg(b + 12);
        bus.key_mode = 1'b1;
        at_neg(b + 17);
        bus.key_step = 1'b0;                 // restart lands at b+24
        at_neg(b + 20);
        bus.key_mode = 1'b0;                 // next mode press lands at b+27
        at_neg(b + 26);
        check_time("up_tick1", b + 12);
        check_time("up_tick2", b + 17);
        check_time("up_tick3", b + 22);
        check_time("up_restart", b + 24);
        vectors++;
        if (bus.code !== 3'd0) begin miscompares++; $display("FAIL up_restart_code: got %0d expected 0", bus.code); end
        check_empty("up_pending");
        m_code = 3'd0;
    endtask

    task automatic test_auto_down_hold();
        int u0;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd5);
        at_neg(b + 27);
        bus.key_step = 1'b1;
        at_neg(b + 28);
        vectors++;
        if (bus.mode !== 2'd2) begin miscompares++; $display("FAIL down_mode: got %0d expected 2", bus.mode); end
        at_neg(b + 30);
        bus.key_mode = 1'b1;
        at_neg(b + 38);
        bus.key_mode = 1'b0;                 // HOLD lands at b+45
        at_neg(b + 43);
        check_time("down_tick1", b + 32);
        check_time("down_tick2", b + 37);
        check_time("down_tick3", b + 42);
        vectors++;
        if (bus.code !== 3'd5) begin miscompares++; $display("FAIL down_code: got %0d expected 5", bus.code); end
        at_neg(b + 46);
        vectors++;
        if (bus.mode !== 2'd3) begin miscompares++; $display("FAIL hold_mode: got %0d expected 3", bus.mode); end
        u0 = upd_total;
        at_neg(b + 50);
        bus.key_mode = 1'b1;
        at_neg(b + 55);
        bus.key_step = 1'b0;
        at_neg(b + 65);
        bus.key_step = 1'b1;
        at_neg(b + 70);
        bus.key_step = 1'b0;
        at_neg(b + 80);
        bus.key_step = 1'b1;
        at_neg(b + 100);
        vectors++;
        if (upd_total !== u0) begin miscompares++; $display("FAIL hold_pulses: got %0d expected 0", upd_total - u0); end
        vectors++;
        if (bus.code !== 3'd5) begin miscompares++; $display("FAIL hold_code: got %0d expected 5", bus.code); end
        bus.key_mode = 1'b0;                 // MANUAL lands at b+107
        at_neg(b + 110);
        bus.key_mode = 1'b1;
        at_neg(b + 112);
        vectors++;
        if (bus.mode !== 2'd0) begin miscompares++; $display("FAIL manual_again_mode: got %0d expected 0", bus.mode); end
        m_code = 3'd6;
        exp_q.push_back(m_code);
        at_neg(b + 115);
        bus.key_step = 1'b0;                 // lands at b+122
        at_neg(b + 125);
        bus.key_step = 1'b1;
        at_neg(b + 135);
        check_time("resume_step", b + 122);
        vectors++;
        if (bus.code !== 3'd6) begin miscompares++; $display("FAIL resume_code: got %0d expected 6", bus.code); end
        check_empty("down_hold_pending");
    endtask

    task automatic test_simultaneous();
        int u0;
        int b2;
        u0 = upd_total;
        b2 = cyc;
        bus.key_step = 1'b0;
        bus.key_mode = 1'b0;                 // both land at b2+7
        at_neg(b2 + 8);
        vectors++;
        if (bus.mode !== 2'd1) begin miscompares++; $display("FAIL simul_mode: got %0d expected 1", bus.mode); end
        vectors++;
        if (bus.code !== m_code) begin miscompares++; $display("FAIL simul_code: got %0d expected %0d", bus.code, m_code); end
        vectors++;
        if (bus.code_upd !== 1'b0) begin miscompares++; $display("FAIL simul_upd: got %b expected 0", bus.code_upd); end
        at_neg(b2 + 11);
        vectors++;
        if (upd_total !== u0) begin miscompares++; $display("FAIL simul_pulses: got %0d expected 0", upd_total - u0); end
        sb_en        = 1'b0;
        bus.key_step = 1'b1;
        bus.key_mode = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_manual_steps();
        test_glitch_and_hold();
        test_auto_up();
        test_auto_down_hold();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
